// File: rtl/sram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sram_pkg
// Purpose  : Shared types and constants for the board SRAM controller.
//            Defines the 512K x 16 SRAM geometry and the controller state set.
// Revision : 1.0  initial release
// ============================================================================
package sram_pkg;

  // Geometry of the on-board asynchronous SRAM (512K words x 16 bits)
  localparam int SRAM_ADDR_W = 19;
  localparam int SRAM_DAT_W  = 16;

  // Controller sequencing states
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD       = 3'd1,
    WR_SETUP = 3'd2,
    WR_PULSE = 3'd3,
    WR_HOLD  = 3'd4
  } state_e;

  // Larger of two integers, used to size the shared wait counter
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sram_ctrl
// Purpose  : Single-port controller for the 512K x 16 asynchronous SRAM.
//            Turns a valid/ready request into sequenced ADR/DAT/CS/OE/WE pin
//            activity. All pin outputs are registered. Read data comes back
//            on a one-cycle rsp_valid strobe. The DAT tristate lives in chip.
// Revision : 1.0  initial release
// ============================================================================
module sram_ctrl
  import sram_pkg::*;
#(
  parameter int ADDR_W  = SRAM_ADDR_W,
  parameter int DATA_W  = SRAM_DAT_W,
  parameter int RD_WAIT = 2,
  parameter int WR_WAIT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] sram_adr,
  output logic [DATA_W-1:0] sram_dat_o,
  input  logic [DATA_W-1:0] sram_dat_i,
  output logic              sram_dat_oe,
  output logic              sram_cs_n,
  output logic              sram_oe_n,
  output logic              sram_we_n
);

  // Shared down-counter for the OE and WE pulse windows
  localparam int CNT_W = $clog2(max_int(RD_WAIT, WR_WAIT) + 1);

  // Both strobe windows must be at least one cycle wide
  if (RD_WAIT < 1 || WR_WAIT < 1) begin : g_bad_wait
    $error("sram_ctrl: RD_WAIT and WR_WAIT must both be >= 1");
  end

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   adr_q, adr_d;
  logic [DATA_W-1:0]   dat_q, dat_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                dat_oe_q, dat_oe_d;
  logic                cs_n_q, cs_n_d;
  logic                oe_n_q, oe_n_d;
  logic                we_n_q, we_n_d;
  logic                accept;

  assign req_ready = (state_q == IDLE) && !reset;
  assign accept    = req_valid && req_ready;

  // State register plus every registered pin and response output
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      adr_q       <= '0;
      dat_q       <= '0;
      rdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      dat_oe_q    <= 1'b0;
      cs_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      rdata_q     <= rdata_d;
      rsp_valid_q <= rsp_valid_d;
      dat_oe_q    <= dat_oe_d;
      cs_n_q      <= cs_n_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
    end
  end

  // Next-state sequencing: every access ends back in IDLE for bus turnaround
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (accept) state_d = req_we ? WR_SETUP : RD;
      RD:       if (cnt_q == '0) state_d = IDLE;
      WR_SETUP: state_d = WR_PULSE;
      WR_PULSE: if (cnt_q == '0) state_d = WR_HOLD;
      WR_HOLD:  state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Next values for pins and counter; strobes default to the idle level
  always_comb begin
    cnt_d       = cnt_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    rdata_d     = rdata_q;
    rsp_valid_d = 1'b0;
    dat_oe_d    = 1'b0;
    cs_n_d      = 1'b1;
    oe_n_d      = 1'b1;
    we_n_d      = 1'b1;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          adr_d  = req_addr;
          dat_d  = req_wdata;
          cs_n_d = 1'b0;
          if (req_we) begin
            dat_oe_d = 1'b1;
          end else begin
            oe_n_d = 1'b0;
            cnt_d  = CNT_W'(RD_WAIT - 1);
          end
        end
      end
      RD: begin
        if (cnt_q == '0) begin
          // Last OE cycle: capture the pins, release the strobes
          rsp_valid_d = 1'b1;
          rdata_d     = sram_dat_i;
        end else begin
          cs_n_d = 1'b0;
          oe_n_d = 1'b0;
          cnt_d  = cnt_q - CNT_W'(1);
        end
      end
      WR_SETUP: begin
        cs_n_d   = 1'b0;
        dat_oe_d = 1'b1;
        we_n_d   = 1'b0;
        cnt_d    = CNT_W'(WR_WAIT - 1);
      end
      WR_PULSE: begin
        cs_n_d   = 1'b0;
        dat_oe_d = 1'b1;
        if (cnt_q != '0) begin
          we_n_d = 1'b0;
          cnt_d  = cnt_q - CNT_W'(1);
        end
      end
      WR_HOLD: begin
        // Strobes return to idle; data/address hold through this cycle
      end
      default: begin
      end
    endcase
  end

  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rdata_q;
  assign sram_adr    = adr_q;
  assign sram_dat_o  = dat_q;
  assign sram_dat_oe = dat_oe_q;
  assign sram_cs_n   = cs_n_q;
  assign sram_oe_n   = oe_n_q;
  assign sram_we_n   = we_n_q;

endmodule
`default_nettype wire

// File: tb/tb_sram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_ctrl
// Purpose  : Self-checking bench for sram_ctrl with a pin-level SRAM model,
//            a transaction-level reference memory and a scoreboard monitor.
// Revision : 1.0  initial release
// ============================================================================
module tb_sram_ctrl;

  localparam int AW      = 19;
  localparam int DW      = 16;
  localparam int RD_WAIT = 2;
  localparam int WR_WAIT = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          req_ready;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] sram_adr;
  logic [DW-1:0] sram_dat_o;
  logic [DW-1:0] sram_dat_i = 16'hA5A5;
  logic          sram_dat_oe, sram_cs_n, sram_oe_n, sram_we_n;

  always #5 clk = ~clk;

  sram_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RD_WAIT(RD_WAIT), .WR_WAIT(WR_WAIT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .sram_adr(sram_adr), .sram_dat_o(sram_dat_o), .sram_dat_i(sram_dat_i),
    .sram_dat_oe(sram_dat_oe), .sram_cs_n(sram_cs_n), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n)
  );

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            acc_cyc;
  } acc_t;

  acc_t          q[$];
  logic [DW-1:0] ref_mem [int];
  logic [DW-1:0] pin_mem [int];
  int            cyc = 0;
  int            checks = 0;
  int            errors = 0;

  // Power-up contents of never-written SRAM words
  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return a[15:0] ^ 16'h3C3C;
  endfunction

  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
    return init_val(a);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Asynchronous SRAM pin model, evaluated mid-cycle
  always @(negedge clk) begin
    if (!sram_cs_n && !sram_we_n && sram_dat_oe) pin_mem[int'(sram_adr)] = sram_dat_o;
    if (!sram_cs_n && !sram_oe_n)
      sram_dat_i = pin_mem.exists(int'(sram_adr)) ? pin_mem[int'(sram_adr)] : init_val(sram_adr);
    else
      sram_dat_i = 16'hA5A5;
  end

  always @(posedge clk) cyc++;

  // Monitor / scoreboard: samples just after each rising edge
  logic prev_ready = 1'b1;
  int   we_run = 0;
  acc_t m;
  always @(posedge clk) begin
    #1;
    if (reset) begin
      chk("rst_strobes", {sram_cs_n, sram_oe_n, sram_we_n, sram_dat_oe}, 4'b1110);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_rdata", rsp_rdata, 0);
      chk("rst_adr", sram_adr, 0);
      chk("rst_dat_o", sram_dat_o, 0);
      chk("rst_ready", req_ready, 0);
      q.delete();
      we_run = 0;
      prev_ready = 1'b1;
    end else begin
      chk("no_contention", sram_dat_oe && !sram_oe_n, 0);
      if (!sram_we_n) we_run++;
      else if (we_run > 0) begin
        chk("we_n_low_cycles", we_run, WR_WAIT);
        we_run = 0;
      end
      if (req_ready) begin
        chk("idle_strobes", {sram_cs_n, sram_oe_n, sram_we_n, sram_dat_oe}, 4'b1110);
        if (!prev_ready) begin
          chk("pending_at_completion", q.size(), 1);
          if (q.size() > 0) begin
            m = q.pop_front();
            chk(m.we ? "wr_latency" : "rd_latency", cyc - m.acc_cyc, m.we ? WR_WAIT + 2 : RD_WAIT);
            chk("rsp_valid_at_completion", rsp_valid, !m.we);
            if (!m.we) chk("rsp_rdata", rsp_rdata, m.data);
          end
        end else begin
          chk("rsp_valid_idle", rsp_valid, 0);
        end
      end else begin
        chk("pending_while_busy", q.size(), 1);
        if (q.size() > 0) begin
          m = q[0];
          chk("adr_hold", sram_adr, m.addr);
          chk("cs_n_busy", sram_cs_n, 0);
          chk("rsp_valid_busy", rsp_valid, 0);
          if (m.we) begin
            chk("dat_o_hold", sram_dat_o, m.data);
            chk("dat_oe_wr", sram_dat_oe, 1);
            chk("oe_n_wr", sram_oe_n, 1);
          end else begin
            chk("oe_n_rd", sram_oe_n, 0);
            chk("dat_oe_rd", sram_dat_oe, 0);
            chk("we_n_rd", sram_we_n, 1);
          end
        end
      end
      prev_ready = req_ready;
    end
  end

  // Present a request (called at a falling edge); returns at the falling edge
  // after the accepting rising edge with req_valid still high.
  task automatic issue(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                       output int acc);
    acc_t a;
    bit   done = 0;
    acc = -1;
    req_we = we; req_addr = addr; req_wdata = data; req_valid = 1'b1;
    for (int n = 0; n < 100 && !done; n++) begin
      #1;
      if (req_ready) begin
        a.we = we; a.addr = addr; a.acc_cyc = cyc + 1;
        if (we) begin
          ref_mem[int'(addr)] = data;
          a.data = data;
        end else begin
          a.data = ref_rd(addr);
        end
        q.push_back(a);
        acc = a.acc_cyc;
        done = 1;
      end
      @(negedge clk);
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL accept_timeout: request addr 0x%0h not accepted, expected acceptance within 100 cycles", addr);
    end
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  logic [AW-1:0] pool [12];
  int            acc_a, acc_b;

  initial begin
    // Reset held three cycles with a request pending
    reset = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_addr = 19'h00001;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1 chk("ready_after_reset", req_ready, 1);
    issue(0, 19'h00001, 16'h0, acc_a);
    idle(4);

    // Write then read back with gaps
    issue(1, 19'h12345, 16'hBEEF, acc_a);
    idle(6);
    issue(0, 19'h12345, 16'h0, acc_a);
    idle(4);

    // Back-to-back write then read with req_valid held
    issue(1, 19'h00000, 16'h1234, acc_a);
    issue(0, 19'h00000, 16'h0, acc_b);
    chk("wr_to_rd_accept_gap", acc_b - acc_a, WR_WAIT + 3);
    idle(4);

    // Reset in the first WE-low cycle of a write
    issue(1, 19'h55555, 16'hCAFE, acc_a);
    req_valid = 1'b0;
    @(negedge clk);
    chk("we_n_first_pulse", sram_we_n, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_strobes", {sram_cs_n, sram_oe_n, sram_we_n, sram_dat_oe}, 4'b1110);
    chk("abort_rsp_valid", rsp_valid, 0);
    reset = 1'b0;
    #1 chk("ready_after_abort", req_ready, 1);
    ref_mem.delete(int'(19'h55555));
    @(negedge clk);

    // Address changes while a read is in flight
    issue(0, 19'h00010, 16'h0, acc_a);
    req_addr = 19'h7FFFF;
    issue(0, 19'h7FFFF, 16'h0, acc_b);
    chk("toggle_accept_gap", acc_b - acc_a, RD_WAIT + 1);
    idle(3);

    // Randomised traffic over a small address pool
    pool[0] = 19'h00000;
    pool[1] = 19'h7FFFF;
    for (int i = 2; i < 12; i++) pool[i] = 19'($urandom_range(0, 19'h7FFFF)) & 19'h7FFF0 | 19'(i);
    for (int i = 0; i < 300; i++) begin
      int gap;
      issue(1'($urandom_range(0, 1)), pool[$urandom_range(0, 11)], 16'($urandom), acc_a);
      gap = $urandom_range(0, 2);
      if (gap > 0) idle(gap);
    end
    req_valid = 1'b0;

    // Drain
    begin
      bit drained = 0;
      for (int n = 0; n < 50 && !drained; n++) begin
        @(negedge clk);
        if (q.size() == 0 && req_ready) drained = 1;
      end
      if (!drained) begin
        checks++; errors++;
        $display("FAIL drain_timeout: %0d accesses outstanding, expected 0", q.size());
      end
    end
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sram_ctrl.md
# sram_ctrl

Single-port controller for the board's 512K×16 asynchronous SRAM. It turns a valid/ready request interface into correctly sequenced ADR/DAT/RAMCS/RAMOE/RAMWE pin activity, and returns read data on a one-cycle response strobe. The chip top instantiates it in place of the current tie-offs and owns the DAT tristate buffer. Later machine-store logic (EDSAC memory) will act as the request initiator.

## Interface
Parameters:
- ADDR_W, 19, SRAM word-address width
- DATA_W, 16, SRAM data width
- RD_WAIT, 2, cycles RAMOE is held low per read (≥1)
- WR_WAIT, 2, cycles RAMWE is held low per write (≥1)

Ports:
- clk  in  1  100 MHz system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  controller idle; a request is accepted on an edge where req_valid & req_ready
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  word address
- req_wdata  in  DATA_W  write data
- rsp_valid  out  1  one-cycle pulse; rsp_rdata holds valid read data
- rsp_rdata  out  DATA_W  read data, held until the next read completes
- sram_adr  out  ADDR_W  to ADR pins
- sram_dat_o  out  DATA_W  drive value for DAT pins
- sram_dat_i  in  DATA_W  sampled value from DAT pins
- sram_dat_oe  out  1  1 = FPGA drives DAT
- sram_cs_n, sram_oe_n, sram_we_n  out  1 each  active-low strobes to RAMCS/RAMOE/RAMWE

## Operation
- FSM states: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD. Reset state is IDLE.
- req_ready = (state == IDLE) && !reset. It is combinational from state.
- All pin outputs are registered, so no combinational path runs from req_* to sram_*.
- Accept in IDLE: latch req_addr into sram_adr and req_wdata into sram_dat_o.
- Read path: go to RD with cs_n=0, oe_n=0, counter = RD_WAIT−1.
  - Decrement the counter each cycle.
  - On the edge that ends the last RD cycle: rsp_rdata ← sram_dat_i, rsp_valid ← 1, cs_n/oe_n ← 1, state → IDLE.
- Write path:
  - WR_SETUP, 1 cycle: cs_n=0, dat_oe=1, we_n=1.
  - WR_PULSE, WR_WAIT cycles: we_n=0.
  - WR_HOLD, 1 cycle: we_n=1, cs_n=0, dat_oe=1.
  - Then IDLE, with cs_n=1 and dat_oe=0.
  - Writes produce no rsp_valid. Completion is indicated by req_ready returning high.
- Every access passes through at least one IDLE cycle, in which all strobes are high and dat_oe=0. This guarantees bus turnaround, so dat_oe=1 and oe_n=0 never occur in the same cycle.
- sram_adr and sram_dat_o hold their value from acceptance until the next accept. Changes to req_* while busy have no effect.
- Reset, including mid-access: on the next edge cs_n=oe_n=we_n=1, dat_oe=0, sram_adr=0, sram_dat_o=0, rsp_valid=0, rsp_rdata=0, state IDLE.
  - An aborted write leaves the SRAM contents undefined at that address.
  - An aborted read produces no response.

## Timing
- Read: accept at edge k → rsp_valid high for the single cycle after edge k+RD_WAIT. Throughput is one read per RD_WAIT+1 cycles.
- Write: accept at edge k → req_ready high again after edge k+WR_WAIT+2. cs_n and dat_oe are low/high for WR_WAIT+2 cycles; we_n is low for exactly WR_WAIT cycles.
- With the defaults at 100 MHz: a 20 ns OE window for the 10 ns SRAM, plus 10 ns address/data setup and hold around WE.
- rsp_valid never lasts more than one cycle. rsp_valid and req_ready are high together in the completion cycle.

## Structure
- Package sram_pkg holds:
  - the state enum (IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD)
  - SRAM_ADDR_W=19 and SRAM_DAT_W=16 constants, used by chip and sram_ctrl
- sram_ctrl is one module with no sub-modules. The wait counter is $clog2(max(RD_WAIT,WR_WAIT)+1) bits.
- The DAT tristate (sram_dat_o/sram_dat_oe/sram_dat_i ↔ DAT) lives in chip, not here.
- Elaboration-time assertion: RD_WAIT ≥ 1 and WR_WAIT ≥ 1.

## Test plan
- Reset held 3 cycles with req_valid=1 → cs_n=oe_n=we_n=1, dat_oe=0, rsp_valid=0, no accept. req_ready=1 on the first cycle after reset falls.
- Write addr 0x12345 ← 0xBEEF, defaults → sram_adr=0x12345, dat_o=0xBEEF stable for 4 cycles; we_n low exactly 2 middle cycles; ready returns 4 edges after accept.
- Read 0x12345 from the behavioural SRAM model → rsp_valid single pulse 2 edges after accept, rsp_rdata=0xBEEF, oe_n low 2 cycles.
- req_valid held high with write 0x00000←0x1234, then read 0x00000 → exactly one IDLE cycle between; no cycle with dat_oe=1 & oe_n=0; rsp_rdata=0x1234.
- reset asserted during the first WR_PULSE cycle → next cycle all strobes 1, dat_oe=0, state IDLE, no rsp_valid.
- req_addr toggled to 0x7FFFF during a read of 0x00010 → sram_adr stays 0x00010 until the access completes. The new request is accepted only once in IDLE.
